// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - FSM state encodings (IDLE / GNT_I / GNT_D)
//   - requester IDs used by the "last served" register
//   - default watchdog limit
package mem_port_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch / load-store paths, the arbiter and
// the unified memory.
//   fetch : i_req, i_addr -> i_rdata, i_ack, i_err
//   data  : d_req, d_we, d_addr, d_wdata, d_be -> d_rdata, d_ack, d_err
//   memory: mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_rdata, mem_ack
//   stall : core freeze while any access is outstanding
// slave  = arbiter side, master = core + memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import mem_port_arbiter_pkg::*;

    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_ack;
    logic                    i_err;

    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_be;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_ack;
    logic                    d_err;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    logic                    stall;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_ack, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack,
        output stall
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_ack, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack,
        input  stall
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Grant-cycle watchdog.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : restart the count (any cycle that is not an ongoing grant)
//   enable    : a grant cycle without mem_ack
//   expired   : this enabled cycle is the TIMEOUT-th one -> abort now
module mem_arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The count holds the number of already-elapsed unacked grant cycles,
    // so the current cycle is the TIMEOUT-th when it equals TIMEOUT-1.
    assign expired = enable && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and
// load/store. One grant at a time, round-robin on ties, watchdog abort.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : mem_port_arbiter_if.slave (fetch, data, memory, stall)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       in_gnt, expired, abort;

    assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);
    // mem_ack on the terminal cycle wins over the watchdog
    assign abort  = expired && !bus.mem_ack;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_gnt || bus.mem_ack),
        .enable  (in_gnt && !bus.mem_ack),
        .expired (expired)
    );

    // Next state / last-served. A finishing requester hands straight over to
    // the other one if it is waiting; its own req is never looked at again
    // in the ack cycle, so it cannot be re-granted back-to-back.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req && bus.d_req)
                    state_d = (last_q == REQ_I) ? GNT_D : GNT_I;
                else if (bus.i_req)
                    state_d = GNT_I;
                else if (bus.d_req)
                    state_d = GNT_D;
            end
            GNT_I: begin
                if (bus.mem_ack) begin
                    last_d  = REQ_I;
                    state_d = bus.d_req ? GNT_D : IDLE;
                end else if (abort) begin
                    last_d  = REQ_I;
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (bus.mem_ack) begin
                    last_d  = REQ_D;
                    state_d = bus.i_req ? GNT_I : IDLE;
                end else if (abort) begin
                    last_d  = REQ_D;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= REQ_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Output muxes: everything is a function of the registered state, so an
    // asynchronous reset clears the outputs without waiting for a clock.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata = {DATA_WIDTH{1'b0}};
        bus.mem_be    = {(DATA_WIDTH/8){1'b0}};
        bus.i_rdata   = {DATA_WIDTH{1'b0}};
        bus.i_ack     = 1'b0;
        bus.i_err     = 1'b0;
        bus.d_rdata   = {DATA_WIDTH{1'b0}};
        bus.d_ack     = 1'b0;
        bus.d_err     = 1'b0;
        if (state_q == GNT_I) begin
            bus.mem_req  = !abort;
            bus.mem_addr = bus.i_addr;
            bus.mem_be   = {(DATA_WIDTH/8){1'b1}};
            bus.i_ack    = bus.mem_ack || abort;
            bus.i_err    = abort;
            if (bus.mem_ack) bus.i_rdata = bus.mem_rdata;
        end else if (state_q == GNT_D) begin
            bus.mem_req   = !abort;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_be    = bus.d_be;
            bus.d_ack     = bus.mem_ack || abort;
            bus.d_err     = abort;
            if (bus.mem_ack) bus.d_rdata = bus.mem_rdata;
        end
    end

    assign bus.stall = (bus.i_req && !bus.i_ack) || (bus.d_req && !bus.d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A service-slot model predicts who
// owns the memory each cycle and pushes predicted completions; a monitor
// pops them when the DUT acknowledges.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    exp_t qi[$];
    exp_t qd[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   hold_reqs = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: owner 0 = memory free, 1 = fetch, 2 = data.
    // A requester that asks while the memory is free owns it next cycle;
    // a tie goes to whoever was not served last; on completion a waiting
    // other requester takes over immediately.
    int owner = 0;
    int age   = 0;
    int last  = 1;
    always @(negedge clk) begin : model
        int   cur;
        int   other;
        bit   done;
        bit   tmo;
        bit   exp_req;
        bit   ai;
        bit   ad;
        exp_t e;
        cur = rst ? owner : 0;
        done = 0; tmo = 0; exp_req = 0; ai = 0; ad = 0;
        if (cur != 0) begin
            age++;
            if (bus.mem_ack) begin
                done = 1; exp_req = 1;
            end else if (age == TO) begin
                done = 1; tmo = 1;
            end else begin
                exp_req = 1;
            end
        end
        if (done) begin
            e.cyc   = cyc;
            e.err   = tmo;
            e.rdata = tmo ? '0 : bus.mem_rdata;
            if (cur == 1) begin qi.push_back(e); ai = 1; end
            else          begin qd.push_back(e); ad = 1; end
        end
        chk("mem_req", bus.mem_req, exp_req);
        if (cur == 0) begin
            chk("mem_idle_cmd", {bus.mem_we, bus.mem_be, bus.mem_addr}, '0);
            chk("mem_idle_wdata", bus.mem_wdata, '0);
        end else if (exp_req && cur == 1) begin
            chk("mem_addr_i", bus.mem_addr, bus.i_addr);
            chk("mem_we_be_i", {bus.mem_we, bus.mem_be}, {1'b0, 4'hF});
        end else if (exp_req) begin
            chk("mem_addr_d", bus.mem_addr, bus.d_addr);
            chk("mem_wdata_d", bus.mem_wdata, bus.d_wdata);
            chk("mem_we_be_d", {bus.mem_we, bus.mem_be}, {bus.d_we, bus.d_be});
        end
        chk("stall", bus.stall, (bus.i_req && !ai) || (bus.d_req && !ad));
        if (!rst) begin
            owner = 0; age = 0; last = 1;
        end else if (cur == 0) begin
            if (bus.i_req && bus.d_req) owner = (last == 1) ? 2 : 1;
            else if (bus.i_req)         owner = 1;
            else if (bus.d_req)         owner = 2;
        end else if (done) begin
            last  = cur;
            other = 3 - cur;
            age   = 0;
            owner = (!tmo && ((other == 1) ? bus.i_req : bus.d_req)) ? other : 0;
        end
    end

    // Monitor: a DUT ack must line up with a predicted completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        if (qi.size() > 0 && qi[0].cyc == cyc) begin
            e = qi.pop_front();
            chk("i_ack", bus.i_ack, 1'b1);
            if (bus.i_ack) begin
                chk("i_rdata", bus.i_rdata, e.rdata);
                chk("i_err", bus.i_err, e.err);
            end
        end else begin
            chk("i_ack_none", {bus.i_ack, bus.i_err}, 2'b00);
        end
        if (qd.size() > 0 && qd[0].cyc == cyc) begin
            e = qd.pop_front();
            chk("d_ack", bus.d_ack, 1'b1);
            if (bus.d_ack) begin
                chk("d_rdata", bus.d_rdata, e.rdata);
                chk("d_err", bus.d_err, e.err);
            end
        end else begin
            chk("d_ack_none", {bus.d_ack, bus.d_err}, 2'b00);
        end
    end

    // One clock; requesters retire their request after seeing an ack.
    logic ia, da;
    task automatic step();
        @(negedge clk);
        ia = bus.i_ack;
        da = bus.d_ack;
        @(posedge clk);
        #1;
        if (!hold_reqs) begin
            if (ia) bus.i_req = 1'b0;
            if (da) bus.d_req = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && (bus.i_req || bus.d_req); k++) step();
        chk(name, {bus.i_req, bus.d_req}, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;

        // held in reset with a pending fetch, then a 2-cycle fetch
        repeat (3) step();
        rst = 1'b1;
        drain("fetch_done");
        step();

        // tie right after a fetch: store goes first, fetch follows
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0014;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0100;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'hF; bus.mem_rdata = 32'h0000_1234;
        drain("tie_done");
        step();

        // both held continuously: strict alternation
        hold_reqs = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        repeat (9) step();
        hold_reqs = 1'b0;
        drain("rr_done");
        step();

        // watchdog abort, then ack on the terminal cycle
        bus.mem_ack = 1'b0; bus.d_we = 1'b0; bus.d_req = 1'b1;
        drain("timeout_done");
        step();
        bus.d_req = 1'b1;
        repeat (4) step();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5_5A5A;
        step();
        drain("late_ack_done");
        step();

        // reset in the middle of a store, with a fetch also waiting
        bus.mem_ack = 1'b0; bus.d_we = 1'b1; bus.d_req = 1'b1;
        repeat (2) step();
        #2;
        rst = 1'b0; bus.i_req = 1'b1;
        repeat (2) step();
        rst = 1'b1; bus.mem_ack = 1'b1;
        drain("post_reset_done");
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req = 1'b1; bus.i_addr = $urandom;
            end
            if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
                bus.d_be = 4'($urandom_range(0, 15));
            end
            bus.mem_ack   = ($urandom_range(0, 9) < 4);
            bus.mem_rdata = $urandom;
            step();
        end
        bus.mem_ack = 1'b1;
        drain("random_done");
        repeat (3) step();
        chk("scoreboard_empty", qi.size() + qd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
